seg7_seconds_counter: RTL and testbench
=======================================

// Module: seg7_seconds_counter
// PURPOSE
//  Digit source that feeds the seven-segment output of tt_um_toivoh_test (uo_out[6:0], uo_out[7]=dp).
//  Programmable prescaler produces a periodic tick; a mod-10 digit counter advances on each tick.
//  The digit is decoded and driven to the segment pins from registers. Pause/single-step supported.
// PARAMETERS
//  PRESCALE_W   24          prescaler width, >= 8
//  DEFAULT_CMP  9_999_999   reset compare value (1 Hz at 10 MHz clk)
// PORTS
//  clk        in   1  system clock
//  rst_n      in   1  reset, asynchronous, active-low
//  ena        in   1  design enable; low freezes all state
//  run        in   1  1=free-running on prescaler ticks, 0=paused
//  step       in   1  rising edge advances one digit while paused (async pin, 2-FF synced inside)
//  cfg_valid  in   1  load compare value this cycle
//  cfg_data   in   8  compare upper byte
//  segments   out  7  {g,f,e,d,c,b,a}, active high, registered
//  dp         out  1  decimal point, registered
//  tick       out  1  one-cycle pulse, coincident with each digit change
//  digit      out  4  current digit 0..9, registered
// BEHAVIOUR
//  - Reset is asynchronous and active-low: one clk, rst_n async active-low.
//  - Reset values: cnt=0, cmp=DEFAULT_CMP, digit=0, segments=7'b0111111, dp=0, tick=0, step sync regs=0.
//  - ena=0: every register holds (incl. step synchronizer); tick=0 that cycle.
//  - Compare load: cfg_valid=1 & ena -> cmp <= {cfg_data, {(PRESCALE_W-8){1'b1}}} (W==8: cmp=cfg_data); cnt <= 0.
//  - Prescaler (run=1): cnt==cmp -> cnt<=0 and advance; else cnt<=cnt+1. cmp=0 -> advance every cycle.
//  - run=0: cnt holds; step rising edge (on synced signal) -> advance. step ignored while run=1.
//  - Advance: digit <= (digit==9)?0:digit+1; segments <= decode(next digit); tick <= 1 for that cycle.
//    Digit, segments and tick all update on the same edge (1 cycle after terminal count / synced edge).
//  - Simultaneous cfg_valid and terminal count: load wins, no advance, tick=0.
//  - Simultaneous cfg_valid and step edge while paused: both take effect (load + advance).
//  - run falling mid-count: cnt frozen, resumes from same value when run rises.
//  - Decode table (g..a): 0=0111111 1=0000110 2=1011011 3=1001111 4=1100110
//    5=1101101 6=1111101 7=0000111 8=1111111 9=1101111; digit >9 unreachable, decodes to 0000000.
// CONFIGURATION
//  - SEG7_DP_BLINK_EN defined: dp toggles on every advance (reset 0) -> half-rate blink.
//  - Not defined: dp register removed, dp tied 0.
// STRUCTURE
//  - Package seg7_pkg: SEG7_W=7, digit pattern constants SEG7_D0..SEG7_D9, SEG7_BLANK,
//    function seg7_decode(logic[3:0]) -> logic[6:0].
//  - Sub-module seg7_prescaler: cnt/cmp registers, cfg load, run gating; emits terminal-count strobe.
//  - Top: step synchronizer + edge detect, digit counter, output registers, optional dp.
// TESTING
//  - Reset: rst_n low mid-count (async, no clk edge) -> digit=0, segments=0111111, tick=0, dp=0 immediately.
//  - PRESCALE_W=8, cfg_data=3, run=1 -> tick every 4 cycles; digits 1,2,...,9,0 with table patterns.
//  - cfg_valid on the terminal-count cycle -> no tick, cnt=0, next tick exactly cmp+1 cycles later.
//  - run=0, three step pulses (each 4 clks high) -> digit +3, exactly three ticks; step with run=1 -> no change.
//  - ena=0 for 10 cycles mid-count -> digit/cnt frozen, tick=0; resume reproduces remaining period exactly.
//  - SEG7_DP_BLINK_EN on: dp 0->1->0 across 2 ticks; off: dp constant 0.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared widths, seven-segment digit patterns and decode/increment helpers.
package seg7_pkg;

    localparam int unsigned SEG7_W  = 7;
    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned CFG_W   = 8;

    // Patterns are {g,f,e,d,c,b,a}, active high.
    localparam logic [SEG7_W-1:0] SEG7_D0    = 7'b0111111;
    localparam logic [SEG7_W-1:0] SEG7_D1    = 7'b0000110;
    localparam logic [SEG7_W-1:0] SEG7_D2    = 7'b1011011;
    localparam logic [SEG7_W-1:0] SEG7_D3    = 7'b1001111;
    localparam logic [SEG7_W-1:0] SEG7_D4    = 7'b1100110;
    localparam logic [SEG7_W-1:0] SEG7_D5    = 7'b1101101;
    localparam logic [SEG7_W-1:0] SEG7_D6    = 7'b1111101;
    localparam logic [SEG7_W-1:0] SEG7_D7    = 7'b0000111;
    localparam logic [SEG7_W-1:0] SEG7_D8    = 7'b1111111;
    localparam logic [SEG7_W-1:0] SEG7_D9    = 7'b1101111;
    localparam logic [SEG7_W-1:0] SEG7_BLANK = 7'b0000000;

    function automatic logic [SEG7_W-1:0] seg7_decode(input logic [DIGIT_W-1:0] d);
        logic [SEG7_W-1:0] seg;
        case (d)
            4'd0:    seg = SEG7_D0;
            4'd1:    seg = SEG7_D1;
            4'd2:    seg = SEG7_D2;
            4'd3:    seg = SEG7_D3;
            4'd4:    seg = SEG7_D4;
            4'd5:    seg = SEG7_D5;
            4'd6:    seg = SEG7_D6;
            4'd7:    seg = SEG7_D7;
            4'd8:    seg = SEG7_D8;
            4'd9:    seg = SEG7_D9;
            default: seg = SEG7_BLANK;
        endcase
        return seg;
    endfunction

    function automatic logic [DIGIT_W-1:0] digit_next(input logic [DIGIT_W-1:0] d);
        return (d == DIGIT_W'(9)) ? DIGIT_W'(0) : d + DIGIT_W'(1);
    endfunction

endpackage

// File: rtl/seg7_prescaler.sv
// Programmable prescaler: counts up to a loadable compare value and flags the terminal-count cycle.
module seg7_prescaler
    import seg7_pkg::*;
#(
    parameter int unsigned PRESCALE_W  = 24,
    parameter int unsigned DEFAULT_CMP = 9_999_999
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             run,
    input  logic             cfg_valid,
    input  logic [CFG_W-1:0] cfg_data,
    output logic             tc_c
);

    logic [PRESCALE_W-1:0] cnt_q, cnt_d;
    logic [PRESCALE_W-1:0] cmp_q, cmp_d;
    logic [PRESCALE_W-1:0] load_val;

    // Loaded byte sits in the top bits; the remaining low bits are all ones.
    always_comb begin
        load_val                          = '1;
        load_val[PRESCALE_W-1 -: CFG_W]   = cfg_data;
    end

    // A load takes priority over a terminal count and suppresses that advance.
    always_comb begin
        cnt_d = cnt_q;
        cmp_d = cmp_q;
        tc_c  = 1'b0;
        if (ena) begin
            if (cfg_valid) begin
                cmp_d = load_val;
                cnt_d = '0;
            end else if (run) begin
                if (cnt_q == cmp_q) begin
                    cnt_d = '0;
                    tc_c  = 1'b1;
                end else begin
                    cnt_d = cnt_q + PRESCALE_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            cmp_q <= PRESCALE_W'(DEFAULT_CMP);
        end else begin
            cnt_q <= cnt_d;
            cmp_q <= cmp_d;
        end
    end

endmodule

// File: rtl/seg7_seconds_counter.sv
// Mod-10 digit counter driving registered seven-segment outputs from a prescaler tick or a step pin.
// Optional feature: define SEG7_DP_BLINK_EN to toggle dp on every digit advance.
module seg7_seconds_counter
    import seg7_pkg::*;
#(
    parameter int unsigned PRESCALE_W  = 24,
    parameter int unsigned DEFAULT_CMP = 9_999_999
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               run,
    input  logic               step,
    input  logic               cfg_valid,
    input  logic [CFG_W-1:0]   cfg_data,
    output logic [SEG7_W-1:0]  segments,
    output logic               dp,
    output logic               tick,
    output logic [DIGIT_W-1:0] digit
);

    logic                tc_c;
    logic                step_edge_c;
    logic                advance_c;
    logic [DIGIT_W-1:0]  digit_nxt_c;

    logic                step_meta_q, step_meta_d;
    logic                step_sync_q, step_sync_d;
    logic                step_prev_q, step_prev_d;
    logic [DIGIT_W-1:0]  digit_q, digit_d;
    logic [SEG7_W-1:0]   segments_q, segments_d;
    logic                tick_q, tick_d;
`ifdef SEG7_DP_BLINK_EN
    logic                dp_q, dp_d;
`endif

    seg7_prescaler #(
        .PRESCALE_W  (PRESCALE_W),
        .DEFAULT_CMP (DEFAULT_CMP)
    ) u_prescaler (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .run       (run),
        .cfg_valid (cfg_valid),
        .cfg_data  (cfg_data),
        .tc_c      (tc_c)
    );

    // Step edges only count while paused; the synchronizer keeps tracking the pin either way.
    always_comb begin
        step_meta_d = step_meta_q;
        step_sync_d = step_sync_q;
        step_prev_d = step_prev_q;
        digit_d     = digit_q;
        segments_d  = segments_q;
`ifdef SEG7_DP_BLINK_EN
        dp_d        = dp_q;
`endif
        step_edge_c = step_sync_q & ~step_prev_q;
        advance_c   = ena & (tc_c | (~run & step_edge_c));
        digit_nxt_c = digit_next(digit_q);
        tick_d      = advance_c;

        if (ena) begin
            step_meta_d = step;
            step_sync_d = step_meta_q;
            step_prev_d = step_sync_q;
        end
        if (advance_c) begin
            digit_d    = digit_nxt_c;
            segments_d = seg7_decode(digit_nxt_c);
`ifdef SEG7_DP_BLINK_EN
            dp_d       = ~dp_q;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_meta_q <= 1'b0;
            step_sync_q <= 1'b0;
            step_prev_q <= 1'b0;
            digit_q     <= '0;
            segments_q  <= SEG7_D0;
            tick_q      <= 1'b0;
`ifdef SEG7_DP_BLINK_EN
            dp_q        <= 1'b0;
`endif
        end else begin
            step_meta_q <= step_meta_d;
            step_sync_q <= step_sync_d;
            step_prev_q <= step_prev_d;
            digit_q     <= digit_d;
            segments_q  <= segments_d;
            tick_q      <= tick_d;
`ifdef SEG7_DP_BLINK_EN
            dp_q        <= dp_d;
`endif
        end
    end

    assign segments = segments_q;
    assign tick     = tick_q;
    assign digit    = digit_q;
`ifdef SEG7_DP_BLINK_EN
    assign dp       = dp_q;
`else
    assign dp       = 1'b0;
`endif

endmodule

// File: tb/tb_seg7_seconds_counter.sv
// Scoreboard bench for seg7_seconds_counter at PRESCALE_W=8; expected ticks are queued when stimulus is driven.
module tb_seg7_seconds_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       run;
    logic       step;
    logic       cfg_valid;
    logic [7:0] cfg_data;
    logic [6:0] segments;
    logic       dp;
    logic       tick;
    logic [3:0] digit;

    typedef struct {
        int   cyc;
        int   dig;
        logic dp;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   adv_n  = 0;
    int   n_chk  = 0;
    int   n_pass = 0;

    logic [6:0] seg_tab [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                                 7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};

    seg7_seconds_counter #(
        .PRESCALE_W  (8),
        .DEFAULT_CMP (5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .run       (run),
        .step      (step),
        .cfg_valid (cfg_valid),
        .cfg_data  (cfg_data),
        .segments  (segments),
        .dp        (dp),
        .tick      (tick),
        .digit     (digit)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Each queued entry is one expected digit advance at an absolute cycle number.
    task automatic push_exp(input int at);
        exp_t e;
        adv_n++;
        e.cyc = at;
        e.dig = adv_n % 10;
`ifdef SEG7_DP_BLINK_EN
        e.dp  = adv_n[0];
`else
        e.dp  = 1'b0;
`endif
        q.push_back(e);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && tick === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_tick", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("tick_cycle", 32'(cyc), 32'(e.cyc));
                chk("tick_digit", 32'(digit), 32'(e.dig));
                chk("tick_segments", 32'(segments), 32'(seg_tab[e.dig]));
                chk("tick_dp", 32'(dp), 32'(e.dp));
            end
        end
    end

    initial begin
        int r, c0, p, t, s;
        rst_n = 1'b0; ena = 1'b1; run = 1'b0; step = 1'b0;
        cfg_valid = 1'b0; cfg_data = 8'd0;
        @(negedge clk); @(negedge clk);
        chk("reset_digit", 32'(digit), 32'd0);
        chk("reset_segments", 32'(segments), 32'(seg_tab[0]));
        chk("reset_tick", 32'(tick), 32'd0);
        chk("reset_dp", 32'(dp), 32'd0);

        // Default compare of 5 gives a 6-cycle period.
        r = cyc; rst_n = 1'b1; run = 1'b1;
        push_exp(r + 6);
        push_exp(r + 12);

        // Load compare 3 -> period 4, full sweep of digits.
        wait_until(r + 13); c0 = cyc; cfg_valid = 1'b1; cfg_data = 8'd3;
        wait_until(r + 14); cfg_valid = 1'b0;
        for (int k = 1; k <= 10; k++) push_exp(c0 + 1 + 4 * k);

        // Load on the terminal-count cycle suppresses that advance.
        wait_until(c0 + 44); cfg_valid = 1'b1; cfg_data = 8'd2;
        wait_until(c0 + 45); cfg_valid = 1'b0; p = cyc;
        for (int k = 1; k <= 3; k++) push_exp(p + 3 * k);
        t = p + 9;

        // Freeze with ena low for 10 cycles mid-count.
        wait_until(t + 1); ena = 1'b0;
        wait_until(t + 6);
        chk("freeze_digit", 32'(digit), 32'(adv_n % 10));
        chk("freeze_tick", 32'(tick), 32'd0);
        wait_until(t + 11); ena = 1'b1;
        push_exp(t + 13);
        push_exp(t + 16);

        // Step pulse while running is ignored (long period so no prescaler tick).
        wait_until(t + 17); cfg_valid = 1'b1; cfg_data = 8'd255;
        wait_until(t + 18); cfg_valid = 1'b0; step = 1'b1;
        wait_until(t + 22); step = 1'b0;
        wait_until(t + 30);
        chk("step_run_digit", 32'(digit), 32'(adv_n % 10));
        chk("step_run_queue", 32'(q.size()), 32'd0);

        // Paused: each step pulse advances once, three sync cycles after its rising edge.
        run = 1'b0; s = t + 32;
        for (int i = 0; i < 4; i++) push_exp(s + 8 * i + 3);
        for (int i = 0; i < 4; i++) begin
            wait_until(s + 8 * i);     step = 1'b1;
            wait_until(s + 8 * i + 4); step = 1'b0;
        end
        wait_until(s + 32);
        chk("step_queue", 32'(q.size()), 32'd0);
        chk("step_digit", 32'(digit), 32'(adv_n % 10));

        // Asynchronous reset between clock edges.
        run = 1'b1;
        wait_until(s + 36);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_digit", 32'(digit), 32'd0);
        chk("async_rst_segments", 32'(segments), 32'(seg_tab[0]));
        chk("async_rst_tick", 32'(tick), 32'd0);
        chk("async_rst_dp", 32'(dp), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
